// File: rtl/adpcm_mul_pkg.sv
// Shared types and default widths for the adpcm_main multiplier arbiter.
package adpcm_mul_pkg;
    localparam int NUM_REQ_DEF = 4;
    localparam int A_WIDTH_DEF = 16;
    localparam int B_WIDTH_DEF = 32;
    localparam int P_WIDTH_DEF = 47;
    localparam int REQ_ID_W    = $clog2(NUM_REQ_DEF);

    typedef struct packed {
        logic                valid;
        logic [REQ_ID_W-1:0] id;
    } mul_tag_t;
endpackage

// File: rtl/adpcm_main_mul_arbiter_if.sv
// Requester-side bus of the shared multiplier: operand pairs in, tagged products out.
interface adpcm_main_mul_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int A_WIDTH = 16,
    parameter int B_WIDTH = 32,
    parameter int P_WIDTH = 47
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*A_WIDTH-1:0] req_a;
    logic [NUM_REQ*B_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [P_WIDTH-1:0]         rsp_data;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/adpcm_mul_tag_pipe.sv
// Requester-id shift register that tracks the multiplier pipeline stage for stage.
module adpcm_mul_tag_pipe
    import adpcm_mul_pkg::*;
#(
    parameter int MUL_LATENCY = 1
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     ce,
    input  mul_tag_t tag_in,
    output mul_tag_t tag_out,
    output logic     any_valid
);
    mul_tag_t stage [MUL_LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MUL_LATENCY; i++) stage[i] <= '0;
        end else if (ce) begin
            stage[0] <= tag_in;
            for (int i = 1; i < MUL_LATENCY; i++) stage[i] <= stage[i-1];
        end
    end

    assign tag_out = stage[MUL_LATENCY-1];

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < MUL_LATENCY; i++) any_valid = any_valid | stage[i].valid;
    end
endmodule

// File: rtl/adpcm_main_mul_arbiter.sv
// Round-robin sharing of one pipelined signed multiplier among NUM_REQ requesters;
// products are routed back by a tag pipe that moves in lockstep with the multiplier.
module adpcm_main_mul_arbiter
    import adpcm_mul_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEF,
    parameter int A_WIDTH     = A_WIDTH_DEF,
    parameter int B_WIDTH     = B_WIDTH_DEF,
    parameter int P_WIDTH     = P_WIDTH_DEF,
    parameter int MUL_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ce,
    adpcm_main_mul_arbiter_if.slave  bus,
    output logic                     idle,
    output logic                     mul_ce,
    output logic [A_WIDTH-1:0]       mul_din0,
    output logic [B_WIDTH-1:0]       mul_din1,
    input  logic [P_WIDTH-1:0]       mul_dout
);
    logic [REQ_ID_W-1:0] ptr;
    logic [REQ_ID_W-1:0] win;
    logic                found;
    logic                grant;
    logic                tags_busy;
    mul_tag_t            tag_in;
    mul_tag_t            tag_out;

    // First valid requester at or after ptr, wrapping around.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = REQ_ID_W'(idx);
            end
        end
    end

    assign grant = found & ce & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
        end
    end

    assign tag_in = {grant, win};

    adpcm_mul_tag_pipe #(
        .MUL_LATENCY (MUL_LATENCY)
    ) u_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .tag_in    (tag_in),
        .tag_out   (tag_out),
        .any_valid (tags_busy)
    );

    // A tag still visible during a reset cycle belongs to a discarded op.
    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        mul_din0      = '0;
        mul_din1      = '0;
        if (grant) bus.req_ready[win] = 1'b1;
        if (found) begin
            mul_din0 = bus.req_a[int'(win)*A_WIDTH +: A_WIDTH];
            mul_din1 = bus.req_b[int'(win)*B_WIDTH +: B_WIDTH];
        end
        if (ce && !reset && tag_out.valid) bus.rsp_valid[tag_out.id] = 1'b1;
    end

    assign bus.rsp_data = mul_dout;
    assign mul_ce       = ce;
    assign idle         = ~tags_busy;
endmodule

// File: tb/tb_adpcm_main_mul_arbiter.sv
// Directed vector table plus randomized traffic checked against a queue-based model.
module tb_adpcm_main_mul_arbiter;
    localparam int N = 4;
    localparam int AW = 16;
    localparam int BW = 32;
    localparam int PW = 47;
    localparam int L = 1;

    logic clk = 1'b0;
    logic reset;
    logic ce;
    logic idle;
    logic mul_ce;
    logic [AW-1:0] mul_din0;
    logic [BW-1:0] mul_din1;
    logic [PW-1:0] mul_dout;

    adpcm_main_mul_arbiter_if #(.NUM_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW)) bus ();

    adpcm_main_mul_arbiter #(
        .NUM_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .MUL_LATENCY(L)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .bus      (bus.slave),
        .idle     (idle),
        .mul_ce   (mul_ce),
        .mul_din0 (mul_din0),
        .mul_din1 (mul_din1),
        .mul_dout (mul_dout)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: L register stages, all frozen while ce is low.
    logic [PW-1:0] mpipe [L];
    always @(posedge clk) begin
        if (mul_ce) begin
            mpipe[0] <= PW'($signed(mul_din0) * $signed(mul_din1));
            for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign mul_dout = mpipe[L-1];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        ce;
        logic [3:0]  valid;
        int          a;
        int          b;
        logic [3:0]  exp_ready;
        logic [3:0]  exp_rsp;
        longint      exp_data;
        logic        exp_idle;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic rst, input logic c, input logic [3:0] v,
                                input int a, input int b, input logic [3:0] rdy,
                                input logic [3:0] rsp, input longint data, input logic idl);
        vec_t r;
        r.rst = rst; r.ce = c; r.valid = v; r.a = a; r.b = b;
        r.exp_ready = rdy; r.exp_rsp = rsp; r.exp_data = data; r.exp_idle = idl;
        tbl.push_back(r);
    endfunction

    // Behavioural reference: pointer as an integer, ops in flight as a queue.
    typedef struct {
        int          id;
        logic [PW-1:0] prod;
        int          rem;
    } flight_t;

    flight_t q[$];
    int m_ptr;

    function automatic logic [PW-1:0] ref_prod(input logic [AW-1:0] a, input logic [BW-1:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[PW-1:0];
    endfunction

    initial begin
        logic [3:0]    last_gnt;
        logic [3:0]    exp_ready;
        logic [3:0]    exp_rsp;
        logic [PW-1:0] exp_data;
        logic [PW-1:0] d47;
        int            ew;
        int            idx;
        flight_t       f;

        reset = 1'b1;
        ce = 1'b1;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;

        add(1,1,4'b0000,0,0,             4'b0000,4'b0000,0,1);
        add(0,1,4'b0001,3,-5,            4'b0001,4'b0000,0,1);
        add(0,1,4'b0000,3,-5,            4'b0000,4'b0001,-15,0);
        add(0,1,4'b0000,0,0,             4'b0000,4'b0000,0,1);
        add(1,1,4'b0000,0,0,             4'b0000,4'b0000,0,1);
        add(0,1,4'b1111,1,10,            4'b0001,4'b0000,0,1);
        add(0,1,4'b1111,1,10,            4'b0010,4'b0001,10,0);
        add(0,1,4'b1111,1,10,            4'b0100,4'b0010,20,0);
        add(0,1,4'b1111,1,10,            4'b1000,4'b0100,30,0);
        add(0,1,4'b1111,1,10,            4'b0001,4'b1000,40,0);
        add(0,1,4'b1111,1,10,            4'b0010,4'b0001,10,0);
        add(0,1,4'b0000,1,10,            4'b0000,4'b0010,20,0);
        add(0,1,4'b0000,0,0,             4'b0000,4'b0000,0,1);
        add(0,1,4'b0001,7,-9,            4'b0001,4'b0000,0,1);
        add(0,0,4'b0010,7,-9,            4'b0000,4'b0000,0,0);
        add(0,0,4'b0010,7,-9,            4'b0000,4'b0000,0,0);
        add(0,0,4'b0010,7,-9,            4'b0000,4'b0000,0,0);
        add(0,1,4'b0010,7,-9,            4'b0010,4'b0001,-63,0);
        add(0,1,4'b0000,7,-9,            4'b0000,4'b0010,-72,0);
        add(0,1,4'b0000,0,0,             4'b0000,4'b0000,0,1);
        add(0,1,4'b0100,5,5,             4'b0100,4'b0000,0,1);
        add(1,1,4'b0000,5,5,             4'b0000,4'b0000,0,0);
        add(0,1,4'b0110,2,3,             4'b0010,4'b0000,0,1);
        add(0,1,4'b0100,2,3,             4'b0100,4'b0010,9,0);
        add(0,1,4'b0000,2,3,             4'b0000,4'b0100,12,0);
        add(0,1,4'b0000,0,0,             4'b0000,4'b0000,0,1);
        add(0,1,4'b1000,1,2,             4'b1000,4'b0000,0,1);
        add(0,1,4'b0101,1,2,             4'b0001,4'b1000,8,0);
        add(0,1,4'b0100,1,2,             4'b0100,4'b0001,2,0);
        add(0,1,4'b0000,1,2,             4'b0000,4'b0100,6,0);
        add(0,1,4'b0000,0,0,             4'b0000,4'b0000,0,1);
        add(0,1,4'b0001,-32768,int'(32'h8000_0000), 4'b0001,4'b0000,0,1);
        add(0,1,4'b0010,32766,2147483647,4'b0010,4'b0001,64'h4000_0000_0000,0);
        add(0,1,4'b0000,0,0,             4'b0000,4'b0010,64'd70366596661249,0);
        add(0,1,4'b0000,0,0,             4'b0000,4'b0000,0,1);

        repeat (2) @(posedge clk);
        #1;

        // Requester i presents a+i, b so each response identifies its source.
        foreach (tbl[r]) begin
            reset = tbl[r].rst;
            ce = tbl[r].ce;
            bus.req_valid = tbl[r].valid;
            for (int i = 0; i < N; i++) begin
                bus.req_a[i*AW +: AW] = AW'(tbl[r].a + i);
                bus.req_b[i*BW +: BW] = BW'(tbl[r].b);
            end
            @(negedge clk);
            chk($sformatf("vec%0d ready", r), 64'(bus.req_ready), 64'(tbl[r].exp_ready));
            chk($sformatf("vec%0d rsp_valid", r), 64'(bus.rsp_valid), 64'(tbl[r].exp_rsp));
            chk($sformatf("vec%0d idle", r), 64'(idle), 64'(tbl[r].exp_idle));
            if (tbl[r].exp_rsp != 4'b0000) begin
                d47 = tbl[r].exp_data[PW-1:0];
                chk($sformatf("vec%0d rsp_data", r), 64'(bus.rsp_data), 64'(d47));
            end
            @(posedge clk);
            #1;
        end

        last_gnt = '0;
        q.delete();
        m_ptr = 0;
        for (int n = 0; n < 3000; n++) begin
            reset = (n == 0) || ($urandom_range(0, 99) == 0);
            ce = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < N; i++) begin
                if (!(bus.req_valid[i] && !last_gnt[i])) begin
                    bus.req_valid[i] = ($urandom_range(0, 1) == 1);
                    bus.req_a[i*AW +: AW] = AW'($urandom);
                    bus.req_b[i*BW +: BW] = BW'($urandom);
                end
            end
            @(negedge clk);
            ew = -1;
            if (!reset && ce) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (ew < 0 && bus.req_valid[idx]) ew = idx;
                end
            end
            exp_ready = (ew >= 0) ? 4'(1 << ew) : 4'b0000;
            exp_rsp = 4'b0000;
            exp_data = '0;
            if (!reset && ce && q.size() > 0 && q[0].rem == 0) begin
                exp_rsp = 4'(1 << q[0].id);
                exp_data = q[0].prod;
            end
            chk("rnd ready", 64'(bus.req_ready), 64'(exp_ready));
            chk("rnd rsp_valid", 64'(bus.rsp_valid), 64'(exp_rsp));
            chk("rnd idle", 64'(idle), 64'(q.size() == 0));
            chk("rnd mul_ce", 64'(mul_ce), 64'(ce));
            if (exp_rsp != 4'b0000) chk("rnd rsp_data", 64'(bus.rsp_data), 64'(exp_data));
            if (ew >= 0) begin
                chk("rnd din0", 64'(mul_din0), 64'(bus.req_a[ew*AW +: AW]));
                chk("rnd din1", 64'(mul_din1), 64'(bus.req_b[ew*BW +: BW]));
            end
            last_gnt = bus.req_ready;
            @(posedge clk);
            if (reset) begin
                q.delete();
                m_ptr = 0;
            end else if (ce) begin
                if (q.size() > 0 && q[0].rem == 0) void'(q.pop_front());
                foreach (q[j]) q[j].rem--;
                if (ew >= 0) begin
                    f.id = ew;
                    f.prod = ref_prod(bus.req_a[ew*AW +: AW], bus.req_b[ew*BW +: BW]);
                    f.rem = L - 1;
                    q.push_back(f);
                    m_ptr = (ew + 1) % N;
                end
            end
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
